// File: rtl/pico_reg_sequencer.sv
// pico_reg_sequencer: byte-level command sequencer and 8-bit register bank
// sitting behind the PICO serial front end, clocked by iclk.
//
// The first byte of each transaction is a command. Bit 7 selects write (1)
// or read (0), and bits [6:0] give the start address. Later bytes then
// auto-increment through the bank. Register 0 is a read-only chip ID.
//
// Build option: define PICO_READBACK_EN to enable the POCI read path.
// When it is undefined, read commands park in READ until txn_end, and
// rd_data/rd_load are held at zero.
`default_nettype none

module pico_reg_sequencer #(
    parameter int unsigned  NUM_REGS = 16,
    parameter logic [7:0]   CHIP_ID  = 8'hA5
) (
    input  logic                    iclk,
    input  logic                    rst,
    input  logic                    byte_valid,
    input  logic [7:0]              byte_data,
    input  logic                    txn_end,
    output logic [8*NUM_REGS-1:0]   reg_q,
    output logic                    wr_strobe,
    output logic [6:0]              wr_addr,
    output logic [7:0]              rd_data,
    output logic                    rd_load,
    output logic                    busy,
    output logic                    err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ
    } state_t;

    localparam logic [7:0] NREG = 8'(NUM_REGS);

    state_t                     state;
    logic [6:0]                 addr;
    logic [6:0]                 addr_inc;
    logic                       wr_ok;
    logic [8*NUM_REGS-1:8]      regs_r;

    // Register 0 is the constant chip ID; only registers 1..NUM_REGS-1 hold state.
    assign reg_q    = {regs_r, CHIP_ID};
    assign addr_inc = addr + 7'd1;
    assign wr_ok    = ({1'b0, addr} < NREG);

`ifdef PICO_READBACK_EN
    logic [6:0] load_addr;
    logic [7:0] load_val;
    logic       load_ok;

    // Select the register feeding a read load: the command address in IDLE,
    // otherwise the next auto-incremented address.
    always_comb begin
        load_addr = (state == S_IDLE) ? byte_data[6:0] : addr_inc;
        load_ok   = ({1'b0, load_addr} < NREG);
        load_val  = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            if (load_addr == 7'(k)) begin
                load_val = reg_q[8*k +: 8];
            end
        end
    end
`else
    assign rd_data = '0;
    assign rd_load = 1'b0;
`endif

    // Command decode, address sequencing, register writes and registered outputs.
    always_ff @(posedge iclk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            addr      <= '0;
            regs_r    <= '0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
`ifdef PICO_READBACK_EN
            rd_data   <= '0;
            rd_load   <= 1'b0;
`endif
        end else begin
            wr_strobe <= 1'b0;
`ifdef PICO_READBACK_EN
            rd_load   <= 1'b0;
`endif
            if (txn_end) begin
                // End of transaction beats any coincident byte, which is discarded.
                state <= S_IDLE;
                busy  <= 1'b0;
            end else if (byte_valid) begin
                case (state)
                    S_IDLE: begin
                        addr <= byte_data[6:0];
                        err  <= 1'b0;
                        busy <= 1'b1;
                        if (byte_data[7]) begin
                            state <= S_WRITE;
                        end else begin
                            state <= S_READ;
`ifdef PICO_READBACK_EN
                            rd_load <= 1'b1;
                            if (load_ok) begin
                                rd_data <= load_val;
                            end else begin
                                rd_data <= '0;
                                err     <= 1'b1;
                            end
`endif
                        end
                    end
                    S_WRITE: begin
                        wr_addr <= addr;
                        if (!wr_ok) begin
                            err <= 1'b1;
                        end else if (addr != '0) begin
                            wr_strobe <= 1'b1;
                            for (int unsigned k = 1; k < NUM_REGS; k++) begin
                                if (addr == 7'(k)) begin
                                    regs_r[8*k +: 8] <= byte_data;
                                end
                            end
                        end
                        addr <= addr_inc;
                    end
                    S_READ: begin
`ifdef PICO_READBACK_EN
                        addr    <= addr_inc;
                        rd_load <= 1'b1;
                        if (load_ok) begin
                            rd_data <= load_val;
                        end else begin
                            rd_data <= '0;
                            err     <= 1'b1;
                        end
`endif
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pico_reg_sequencer.sv
// Testbench for pico_reg_sequencer: directed byte sequences, with a
// transaction-level model that is checked against the DUT every cycle, plus
// hand-computed literal checks at key points.
`timescale 1ns/1ps

module tb_pico_reg_sequencer;

    localparam int NR = 16;
`ifdef PICO_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic               iclk = 1'b0;
    logic               rst = 1'b0;
    logic               byte_valid = 1'b0;
    logic [7:0]         byte_data = 8'h00;
    logic               txn_end = 1'b0;
    logic [8*NR-1:0]    reg_q;
    logic               wr_strobe;
    logic [6:0]         wr_addr;
    logic [7:0]         rd_data;
    logic               rd_load;
    logic               busy;
    logic               err;

    int unsigned vectors = 0;
    int unsigned fails = 0;

    pico_reg_sequencer #(.NUM_REGS(NR), .CHIP_ID(8'hA5)) dut (
        .iclk       (iclk),
        .rst        (rst),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .txn_end    (txn_end),
        .reg_q      (reg_q),
        .wr_strobe  (wr_strobe),
        .wr_addr    (wr_addr),
        .rd_data    (rd_data),
        .rd_load    (rd_load),
        .busy       (busy),
        .err        (err)
    );

    always #5 iclk = ~iclk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    logic [7:0] m_regs [NR];
    bit         m_in_txn;
    bit         m_is_write;
    int         m_addr;
    logic       e_wr_strobe, e_rd_load, e_busy, e_err;
    logic [6:0] e_wr_addr;
    logic [7:0] e_rd_data;

    task automatic model_reset();
        foreach (m_regs[i]) m_regs[i] = 8'h00;
        m_regs[0]   = 8'hA5;
        m_in_txn    = 0;
        m_is_write  = 0;
        m_addr      = 0;
        e_wr_strobe = 0;
        e_rd_load   = 0;
        e_busy      = 0;
        e_err       = 0;
        e_wr_addr   = 0;
        e_rd_data   = 0;
    endtask

    task automatic model_read(input int a);
        if (RB) begin
            e_rd_load = 1;
            if (a < NR) e_rd_data = m_regs[a];
            else begin
                e_rd_data = 8'h00;
                e_err = 1;
            end
        end
    endtask

    task automatic model_step(input logic bv, input logic [7:0] bd, input logic te);
        e_wr_strobe = 0;
        e_rd_load   = 0;
        if (te) begin
            m_in_txn = 0;
        end else if (bv) begin
            if (!m_in_txn) begin
                m_in_txn   = 1;
                m_is_write = bd[7];
                m_addr     = int'(bd[6:0]);
                e_err      = 0;
                if (!m_is_write) model_read(m_addr);
            end else if (m_is_write) begin
                e_wr_addr = 7'(m_addr);
                if (m_addr >= NR) e_err = 1;
                else if (m_addr != 0) begin
                    m_regs[m_addr] = bd;
                    e_wr_strobe = 1;
                end
                m_addr = (m_addr + 1) % 128;
            end else if (RB) begin
                m_addr = (m_addr + 1) % 128;
                model_read(m_addr);
            end
        end
        e_busy = m_in_txn;
    endtask

    always @(posedge iclk or posedge rst) begin
        if (rst) model_reset();
        else model_step(byte_valid, byte_data, txn_end);
    end

    // ---------------- per-cycle compare + event capture ----------------
    logic [7:0] wa_q[$];
    logic [7:0] rd_q[$];

    always @(negedge iclk) begin
        for (int k = 0; k < NR; k++)
            chk($sformatf("reg%0d", k), reg_q[8*k +: 8], m_regs[k]);
        chk("wr_strobe", wr_strobe, e_wr_strobe);
        chk("wr_addr", wr_addr, e_wr_addr);
        chk("rd_load", rd_load, e_rd_load);
        chk("rd_data", rd_data, e_rd_data);
        chk("busy", busy, e_busy);
        chk("err", err, e_err);
        if (wr_strobe) wa_q.push_back({1'b0, wr_addr});
        if (rd_load) rd_q.push_back(rd_data);
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b);
        @(posedge iclk); #1;
        byte_valid = 1'b1;
        byte_data  = b;
        @(posedge iclk); #1;
        byte_valid = 1'b0;
        repeat (6) @(posedge iclk);
    endtask

    task automatic end_txn();
        @(posedge iclk); #1;
        txn_end = 1'b1;
        @(posedge iclk); #1;
        txn_end = 1'b0;
        repeat (2) @(posedge iclk);
    endtask

    task automatic settle();
        @(negedge iclk); #1;
    endtask

    task automatic chk_q(input string name, input logic [7:0] q[$], input logic [7:0] exp[$]);
        chk({name, "_count"}, 128'(q.size()), 128'(exp.size()));
        for (int i = 0; i < exp.size() && i < q.size(); i++)
            chk($sformatf("%s[%0d]", name, i), q[i], exp[i]);
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(posedge iclk);
        @(negedge iclk) rst = 1'b0;
        settle();
        chk("lit_reset_reg0", reg_q[7:0], 8'hA5);
        chk("lit_reset_rest", reg_q[8*NR-1:8], '0);
        chk("lit_reset_busy", busy, 1'b0);
        chk("lit_reset_err", err, 1'b0);
        chk("lit_reset_rd_data", rd_data, 8'h00);

        // Write burst
        wa_q.delete();
        send_byte(8'h83);
        settle();
        chk("lit_busy_after_cmd", busy, 1'b1);
        send_byte(8'h11);
        send_byte(8'h22);
        end_txn();
        settle();
        chk("lit_reg3", reg_q[31:24], 8'h11);
        chk("lit_reg4", reg_q[39:32], 8'h22);
        chk("lit_busy_after_end", busy, 1'b0);
        chk_q("lit_wr_addrs", wa_q, '{8'h03, 8'h04});

        // Read burst
        rd_q.delete();
        send_byte(8'h03);
        send_byte(8'hFF);
        send_byte(8'hFF);
        end_txn();
        settle();
        if (RB) chk_q("lit_rd_burst", rd_q, '{8'h11, 8'h22, 8'h00});
        else    chk_q("lit_rd_burst", rd_q, '{});

        // Boundary write
        send_byte(8'h8F);
        send_byte(8'hAA);
        send_byte(8'hBB);
        settle();
        chk("lit_reg15", reg_q[127:120], 8'hAA);
        chk("lit_err_set", err, 1'b1);
        end_txn();

        // Write to register 0
        wa_q.delete();
        send_byte(8'h80);
        settle();
        chk("lit_err_cleared", err, 1'b0);
        send_byte(8'h55);
        end_txn();
        settle();
        chk("lit_reg0_kept", reg_q[7:0], 8'hA5);
        chk("lit_no_strobe", 128'(wa_q.size()), 128'(0));
        rd_q.delete();
        send_byte(8'h00);
        end_txn();
        settle();
        if (RB) chk_q("lit_rd_id", rd_q, '{8'hA5});
        else    chk_q("lit_rd_id", rd_q, '{});

        // txn_end coincident with a data byte
        send_byte(8'h85);
        @(posedge iclk); #1;
        byte_valid = 1'b1; byte_data = 8'h77; txn_end = 1'b1;
        @(posedge iclk); #1;
        byte_valid = 1'b0; txn_end = 1'b0;
        repeat (6) @(posedge iclk);
        settle();
        chk("lit_coincident_busy", busy, 1'b0);
        send_byte(8'h86);
        send_byte(8'h99);
        end_txn();
        settle();
        chk("lit_reg5_untouched", reg_q[47:40], 8'h00);
        chk("lit_reg6", reg_q[55:48], 8'h99);

        // Back-to-back bytes
        send_byte(8'h87);
        @(posedge iclk); #1;
        byte_valid = 1'b1; byte_data = 8'h01;
        @(posedge iclk); #1;
        byte_data = 8'h02;
        @(posedge iclk); #1;
        byte_valid = 1'b0;
        repeat (3) @(posedge iclk);
        end_txn();
        settle();
        chk("lit_reg7_b2b", reg_q[63:56], 8'h01);
        chk("lit_reg8_b2b", reg_q[71:64], 8'h02);

        // Address wrap 127 -> 0 on reads and writes
        rd_q.delete();
        send_byte(8'h7F);
        send_byte(8'hFF);
        settle();
        if (RB) begin
            chk_q("lit_rd_wrap", rd_q, '{8'h00, 8'hA5});
            chk("lit_rd_wrap_err", err, 1'b1);
        end else begin
            chk_q("lit_rd_wrap", rd_q, '{});
            chk("lit_rd_wrap_err", err, 1'b0);
        end
        end_txn();
        send_byte(8'hFF);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        end_txn();
        settle();
        chk("lit_wr_wrap_reg1", reg_q[15:8], 8'h56);
        chk("lit_wr_wrap_err", err, 1'b1);

        // Reset asserted mid-burst
        send_byte(8'h89);
        send_byte(8'h5A);
        settle();
        chk("lit_reg9", reg_q[79:72], 8'h5A);
        @(posedge iclk); #3;
        rst = 1'b1;
        #1;
        chk("lit_midrst_regs", reg_q, {{(8*NR-8){1'b0}}, 8'hA5});
        chk("lit_midrst_busy", busy, 1'b0);
        chk("lit_midrst_err", err, 1'b0);
        chk("lit_midrst_wr_addr", wr_addr, 7'd0);
        chk("lit_midrst_rd_data", rd_data, 8'h00);
        repeat (2) @(posedge iclk);
        @(negedge iclk) rst = 1'b0;
        // First byte after reset is a command
        send_byte(8'h82);
        send_byte(8'h3C);
        end_txn();
        settle();
        chk("lit_postrst_reg2", reg_q[23:16], 8'h3C);

        repeat (2) @(posedge iclk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/pico_reg_sequencer.md
# pico_reg_sequencer

Byte-level command sequencer and register bank sitting behind the PICO serial front end, in the `iclk` domain. It consumes framed bytes and end-of-transaction pulses, and decodes the first byte of each transaction as a read/write command with a start address. It then auto-increments through a bank of 8-bit configuration registers, writing incoming bytes or loading register contents into the POCI readout shift register. Register 0 is a read-only chip ID.

## Interface
Parameters:
- `NUM_REGS`, 16: number of 8-bit registers, legal range 2..128.
- `CHIP_ID`, 8'hA5: constant value of register 0.

Ports:
- `iclk`  in  1  internal clock; the block's only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `byte_valid`  in  1  single-cycle pulse, `iclk`-synchronous; `byte_data` valid this cycle.
- `byte_data`  in  8  received byte.
- `txn_end`  in  1  single-cycle pulse; the serial transaction has ended (sclk stopped).
- `reg_q`  out  8*NUM_REGS  flattened register bank; register k at bits [8k+7:8k].
- `wr_strobe`  out  1  one-cycle pulse when a register is written.
- `wr_addr`  out  7  address of the last write attempt.
- `rd_data`  out  8  byte presented to the POCI shift register.
- `rd_load`  out  1  one-cycle pulse; POCI loads `rd_data`.
- `busy`  out  1  high when state is not IDLE.
- `err`  out  1  sticky out-of-range access flag.

## Operation
- Command byte (first byte after reset or `txn_end`): bit7 = 1 means write, 0 means read. Bits[6:0] give the start address `addr`.
- States: IDLE, WRITE, READ.
- IDLE + `byte_valid`:
  - Latch `addr`, clear `err`.
  - Bit7 = 1: go to WRITE.
  - Bit7 = 0: go to READ and perform a read load at `addr`.
- WRITE + `byte_valid`:
  - `wr_addr` <= `addr`.
  - If 1 <= `addr` < NUM_REGS: register[`addr`] <= `byte_data` and pulse `wr_strobe`.
  - If `addr` == 0: no write and no strobe; `err` is unaffected.
  - If `addr` >= NUM_REGS: no write, no strobe, set `err`.
  - Then `addr` <= `addr` + 1.
- READ + `byte_valid` (host clocking out the previous byte): `addr` <= `addr` + 1, then perform a read load at the new address.
- Read load:
  - `rd_data` <= register[addr], or 8'h00 with `err` set if `addr` >= NUM_REGS.
  - Pulse `rd_load`.
- Address arithmetic is 7-bit and wraps 127 -> 0. Reaching 0 is not an error.
- `txn_end` in any state: go to IDLE. Registers, `rd_data` and `err` are retained.
- `txn_end` coincident with `byte_valid`: `txn_end` wins and the byte is discarded entirely.
- `txn_end` in IDLE: no effect.

## Timing
- Write: `byte_valid` in cycle N -> `reg_q`, `wr_strobe` and `wr_addr` update at the end of cycle N (visible in N+1). `wr_strobe` is high for N+1 only.
- Read: a command or data byte in cycle N -> `rd_data` valid and `rd_load` high in N+1. `rd_data` holds until the next load.
- `busy` rises in N+1 after the command byte, and falls in the cycle after `txn_end`.
- `byte_valid` pulses are at least 8 `iclk` cycles apart by construction upstream. Back-to-back pulses must still be handled one per cycle.
- Reset (asynchronous assert, may occur mid-transaction):
  - State IDLE, `addr` 0.
  - Register 0 reads `CHIP_ID`; all others 8'h00.
  - `rd_data` 8'h00, `wr_addr` 0.
  - `wr_strobe`, `rd_load`, `busy`, `err` all 0.
- After `rst` deasserts, the first `byte_valid` is treated as a command byte.

## Configuration
- `PICO_READBACK_EN` defined: read path as described above.
- `PICO_READBACK_EN` undefined:
  - A read command moves to a READ state that ignores all bytes until `txn_end`.
  - `rd_data` is tied to 8'h00 and `rd_load` to 0.
  - The write path is unchanged.

## Test plan
- Reset, then check the outputs: `reg_q`[7:0] = 8'hA5, all others 0, `busy` = 0, `err` = 0, `rd_data` = 0.
- Write burst: bytes 8'h83, 8'h11, 8'h22, then `txn_end`. Expect reg3 = 8'h11, reg4 = 8'h22, two `wr_strobe` pulses with `wr_addr` 3 then 4, and `busy` low after `txn_end`.
- Read burst after the write burst: bytes 8'h03, 8'hxx, 8'hxx. Expect `rd_load` pulses with `rd_data` 8'h11, 8'h22, 8'h00.
- Boundary write: bytes 8'h8F, 8'hAA, 8'hBB with NUM_REGS = 16. Expect reg15 = 8'hAA, the 8'hBB byte dropped, and `err` = 1. A subsequent command clears `err`.
- Write to register 0: bytes 8'h80, 8'h55. Expect reg0 still 8'hA5 and no `wr_strobe`. A read command 8'h00 returns 8'hA5.
- `txn_end` coincident with a data byte in WRITE: the byte is not written, state returns to IDLE, and the next byte is decoded as a command. `rst` asserted mid-burst gives the full reset values immediately.
